// File: rtl/ula_pkg.sv
`default_nettype none
// ==========================================================================
// ula_pkg - opcode map, FSM state encoding and op classification for ula_seq
// Rev 1.0
// ==========================================================================
package ula_pkg;

  localparam logic [3:0] OP_NOT  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_divide(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_iter.sv
`default_nettype none
// ==========================================================================
// ula_iter - shared WIDTH-step shift-add multiplier / restoring divider
// Rev 1.0
// ==========================================================================
module ula_iter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             is_div;
  logic [SHW-1:0]   cnt;
  logic             busy_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // acc_lo holds the multiplier / dividend being consumed and collects the
  // product low half / quotient; acc_hi is the partial product / remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opb;
    if (is_div) begin
      if (div_shift >= {1'b0, opb}) begin
        nxt_hi = div_diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_hi <= '0;
      acc_lo <= a;
      opb    <= b;
      is_div <= mode;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + SHW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

  // Results are the post-step values so the caller can capture them on the
  // same edge as the final step.
  assign busy = busy_q;
  assign done = busy_q && (cnt == LAST);
  assign lo   = nxt_lo;
  assign hi   = nxt_hi;

endmodule
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ==========================================================================
// ula_seq - handshaked ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU
// Rev 1.0
// ==========================================================================
module ula_seq
  import ula_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_dz,
  output logic             flag_illegal
);

  localparam logic [SHW:0] WBITS = (SHW + 1)'(WIDTH);

  state_t state;
  state_t state_nxt;

  logic [3:0]       op_q;
  logic             accept;
  logic             div_zero;
  logic             go_iter;
  logic             iter_busy;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     inv_amt;
  logic             shift_oor;
  logic [WIDTH-1:0] sc_s;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_carry;
  logic [WIDTH-1:0] it_s;
  logic [WIDTH-1:0] it_hi;

  assign accept   = in_ready && in_valid;
  assign div_zero = is_divide(op) && (b == '0);
  assign go_iter  = is_iterative(op) && !div_zero;

  ula_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && go_iter),
    .mode  (is_divide(op)),
    .a     (a),
    .b     (b),
    .busy  (iter_busy),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = go_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (iter_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !iter_busy;
    out_valid = (state == ST_DONE);
  end

  // Power-of-two WIDTH: b >= WIDTH exactly when any bit above the amount is set.
  always_comb begin
    add_w     = {1'b0, a} + {1'b0, b};
    sub_w     = {1'b0, a} - {1'b0, b};
    amt       = b[SHW-1:0];
    shift_oor = |b[WIDTH-1:SHW];
    inv_amt   = WBITS - {1'b0, amt};
    sc_s      = '0;
    sc_hi     = '0;
    sc_carry  = 1'b0;
    case (op)
      OP_NOT:  sc_s = ~a;
      OP_AND:  sc_s = a & b;
      OP_OR:   sc_s = a | b;
      OP_XOR:  sc_s = a ^ b;
      OP_ADD:  begin sc_s = add_w[WIDTH-1:0]; sc_carry = add_w[WIDTH]; end
      OP_SUB:  begin sc_s = sub_w[WIDTH-1:0]; sc_carry = sub_w[WIDTH]; end
      OP_SLL:  sc_s = shift_oor ? '0 : (a << amt);
      OP_SRL:  sc_s = shift_oor ? '0 : (a >> amt);
      OP_ROL:  sc_s = (a << amt) | (a >> inv_amt);
      OP_ROR:  sc_s = (a >> amt) | (a << inv_amt);
      OP_DIVU: begin sc_s = '1; sc_hi = a;  end
      OP_REMU: begin sc_s = a;  sc_hi = '1; end
      default: ;
    endcase
  end

  // The engine leaves quotient in lo and remainder in hi; REMU swaps them.
  always_comb begin
    it_s  = iter_lo;
    it_hi = iter_hi;
    if (op_q == OP_REMU) begin
      it_s  = iter_hi;
      it_hi = iter_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_NOT;
      s            <= '0;
      s_hi         <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      flag_dz      <= 1'b0;
      flag_illegal <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      if (!go_iter) begin
        s            <= sc_s;
        s_hi         <= sc_hi;
        flag_zero    <= (sc_s == '0);
        flag_carry   <= sc_carry;
        flag_dz      <= div_zero;
        flag_illegal <= (op > OP_ROR);
      end
    end else if ((state == ST_BUSY) && iter_done) begin
      s            <= it_s;
      s_hi         <= it_hi;
      flag_zero    <= (it_s == '0);
      flag_carry   <= 1'b0;
      flag_dz      <= 1'b0;
      flag_illegal <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// ==========================================================================
// tb_ula_seq - vector table with a scoreboard queue, plus reset corner cases
// Rev 1.0
// ==========================================================================
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic [W-1:0] s_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_dz;
  logic         flag_illegal;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] es;
    logic [W-1:0] ehi;
    logic         ez;
    logic         ec;
    logic         ed;
    logic         ei;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  ula_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .s            (s),
    .s_hi         (s_hi),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_dz      (flag_dz),
    .flag_illegal (flag_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] es, input logic [W-1:0] eh,
                              input logic ez, input logic ec, input logic ed, input logic ei,
                              input int lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.es = es; v.ehi = eh;
    v.ez = ez; v.ec = ec; v.ed = ed; v.ei = ei; v.lat = lat;
    return v;
  endfunction

  // Drive one op, scramble the inputs while it is in flight, check the
  // result against the scoreboard, hold for two cycles, then consume it.
  task automatic run_op(input vec_t v, input int idx);
    vec_t e;
    int   lat;
    int   guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_before", idx, in_ready, 1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    #1;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", idx, lat, v.lat);
    e = sb.pop_front();
    if (!out_valid) begin
      chk("out_valid_timeout", idx, out_valid, 1);
    end else begin
      chk("s", idx, s, e.es);
      chk("s_hi", idx, s_hi, e.ehi);
      chk("flag_zero", idx, flag_zero, e.ez);
      chk("flag_carry", idx, flag_carry, e.ec);
      chk("flag_dz", idx, flag_dz, e.ed);
      chk("flag_illegal", idx, flag_illegal, e.ei);
      repeat (2) begin
        @(posedge clk); #1;
        chk("hold_out_valid", idx, out_valid, 1);
        chk("hold_in_ready", idx, in_ready, 0);
        chk("hold_s", idx, s, e.es);
        chk("hold_s_hi", idx, s_hi, e.ehi);
      end
      // in_valid still high with garbage: must not be accepted in DONE.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_in_ready", idx, in_ready, 1);
      chk("post_out_valid", idx, out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vecs.push_back(mk(OP_ADD,  8'hF0, 8'h20, 8'h10, 8'h00, 0, 1, 0, 0, 1));
    vecs.push_back(mk(OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0, 0, 9));
    vecs.push_back(mk(OP_DIVU, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 0, 0, 9));
    vecs.push_back(mk(OP_DIVU, 8'd200, 8'd0, 8'hFF, 8'd200, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_SLL,  8'h81, 8'd9, 8'h00, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ROL,  8'h81, 8'd9, 8'h03, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ROR,  8'h81, 8'd8, 8'h81, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  8'd3, 8'd5, 8'hFE, 8'h00, 0, 1, 0, 0, 1));
    vecs.push_back(mk(4'b1110, 8'h12, 8'h34, 8'h00, 8'h00, 1, 0, 0, 1, 1));
    vecs.push_back(mk(OP_REMU, 8'd200, 8'd7, 8'd4, 8'd28, 0, 0, 0, 0, 9));
    vecs.push_back(mk(OP_REMU, 8'd5, 8'd0, 8'd5, 8'hFF, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_NOT,  8'h5A, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_XOR,  8'hA5, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_OR,   8'h0F, 8'h30, 8'h3F, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRL,  8'h80, 8'd7, 8'h01, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRL,  8'h80, 8'd8, 8'h00, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 1));
    vecs.push_back(mk(OP_MUL,  8'h12, 8'h34, 8'hA8, 8'h03, 0, 0, 0, 0, 9));
    vecs.push_back(mk(OP_SUB,  8'd5, 8'd3, 8'd2, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_DIVU, 8'd7, 8'd200, 8'd0, 8'd7, 1, 0, 0, 0, 9));
    vecs.push_back(mk(OP_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ROR,  8'h81, 8'd1, 8'hC0, 8'h00, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", -1, in_ready, 1);
    chk("rst_out_valid", -1, out_valid, 0);
    chk("rst_s", -1, s, 0);
    chk("rst_s_hi", -1, s_hi, 0);
    chk("rst_flags", -1, {flag_zero, flag_carry, flag_dz, flag_illegal}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

    // Reset during BUSY: the MUL is abandoned and s (0xC0 from the last op) clears.
    op = OP_MUL; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("busy_rst_out_valid", 100, out_valid, 0);
    chk("busy_rst_s", 100, s, 0);
    chk("busy_rst_s_hi", 100, s_hi, 0);
    chk("busy_rst_in_ready", 100, in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("busy_rst_no_pending", 101, out_valid, 0);
    chk("busy_rst_idle", 101, in_ready, 1);
    run_op(mk(OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1), 102);

    // Reset during DONE: result dropped, nothing pending afterwards.
    op = OP_ADD; a = 8'hF0; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_rst_pre_valid", 103, out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("done_rst_out_valid", 103, out_valid, 0);
    chk("done_rst_s", 103, s, 0);
    chk("done_rst_carry", 103, flag_carry, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_rst_no_pending", 104, out_valid, 0);
    run_op(mk(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0, 0, 9), 105);

    chk("scoreboard_empty", 106, sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU; it keeps the same 4-bit opcode encoding for ops 0000-1001 and adds ROR, unsigned divide and remainder.
Single-cycle ops complete one cycle after acceptance. MUL, DIVU and REMU run on a shared iterative engine over WIDTH cycles.
Sits between the instruction decode stage and register writeback. It accepts one operation at a time on a valid/ready pair and presents the result and flags on a second valid/ready pair.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4
SHW, $clog2(WIDTH), derived shift-amount width; not to be overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation
op  in  4  opcode
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result available
out_ready  in  1  consumer takes result
s  out  WIDTH  result (low half for MUL)
s_hi  out  WIDTH  MUL: product high half; DIVU: remainder; REMU: quotient; else 0
flag_zero  out  1  s == 0
flag_carry  out  1  ADD carry-out; SUB borrow (a < b unsigned); else 0
flag_dz  out  1  DIVU/REMU with b == 0
flag_illegal  out  1  reserved opcode 1101-1111

Behaviour:
- Opcodes: 0000 NOT a; 0001 AND; 0010 OR; 0011 XOR; 0100 ADD; 0101 SUB; 0110 SLL; 0111 SRL; 1000 MUL; 1001 ROL; 1010 DIVU; 1011 REMU; 1100 ROR.
- Arithmetic is unsigned, modulo 2^WIDTH on s.
- SLL/SRL shift by the full value of b; if b >= WIDTH, s = 0.
- ROL/ROR rotate by b mod WIDTH; an amount of 0 returns a unchanged.
- FSM states: IDLE, BUSY, DONE.
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0; s, s_hi and all flags = 0; iteration counter = 0.
- IDLE: in_ready=1. On in_valid at a rising edge, latch op/a/b, then:
  - single-cycle op, reserved op, or DIVU/REMU with b=0: result registered, go to DONE;
  - MUL, or DIVU/REMU with b!=0: go to BUSY, counter=0.
- BUSY: in_ready=0. One step per cycle: shift-add for MUL, restoring subtract-shift for DIVU/REMU. After WIDTH steps, register the result and go to DONE.
- DONE: out_valid=1; s, s_hi and flags held stable. On out_ready, go to IDLE.
- in_ready=1 only in IDLE. No new request is accepted in the DONE cycle, even if out_ready is high.
- Latency, acceptance edge to out_valid high: 1 cycle for single-cycle ops; WIDTH+1 cycles for iterative ops.
- Throughput: at most one op per 2 cycles (single-cycle) or per WIDTH+2 cycles (iterative).
- Divide by zero: s = all ones for DIVU; s = a for REMU; s_hi = the other of the pair; flag_dz=1; 1-cycle latency.
- Reserved opcodes: s = 0, s_hi = 0, flag_illegal=1, flag_zero=1.
- Inputs a/b/op are ignored while in_ready=0. Changing them during BUSY must not affect the result.
- out_ready while out_valid=0: ignored.
- rst_n asserted mid-BUSY or mid-DONE: the operation is dropped; all outputs take their reset values immediately, with no pending result after release.

Decomposition:
- Package ula_pkg: opcode localparams (OP_NOT..OP_ROR), FSM state enum, helper function is_iterative(op).
- Sub-module ula_iter: WIDTH-parametrised shift-add multiplier / restoring divider with start, mode, busy/done; instantiated once.
- ula_seq holds the handshake FSM and the combinational single-cycle datapath.

Test Plan (WIDTH=8):
- After reset, ADD a=0xF0 b=0x20, out_ready=1 -> out_valid 1 cycle after accept; s=0x10, flag_carry=1, flag_zero=0; then in_ready=1.
- MUL a=0xFF b=0xFF -> out_valid 9 cycles after accept; s=0x01, s_hi=0xFE. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- DIVU a=200 b=7 -> s=28, s_hi=4, 9-cycle latency. Repeat with b=0 -> s=0xFF, s_hi=200, flag_dz=1, 1-cycle latency.
- SLL a=0x81 b=9 -> s=0x00, flag_zero=1. ROL a=0x81 b=9 -> s=0x03. ROR a=0x81 b=8 -> s=0x81.
- SUB a=3 b=5 -> s=0xFE, flag_carry=1. Opcode 1110 -> s=0, flag_illegal=1.
- Start MUL, pulse rst_n low in BUSY cycle 4 -> out_valid=0 and s=0 immediately; after release, in_ready=1. A following AND 0xF0/0x3C -> s=0x30.
